sum_serial_tx: RTL and testbench
================================

Name: sum_serial_tx

Overview:
- Transmit-side companion to the parallel operand adder.
- On a start request, captures two 8-bit operands, forms their 9-bit sum and shifts it out LSB-first as a UART-style frame on a single output pin.
- Drives that pin's output enable, so the frame can leave through a bidirectional IO.
- Sits between the operand inputs and one uio pin in the top level.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..255.
- DATA_BITS, 9, payload bits per frame (sum[7:0] then carry); fixed, not intended to be overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; low freezes all state
- a_in  in  8  operand A
- b_in  in  8  operand B
- start  in  1  frame request, level-sampled
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- tx  out  1  serial line, idle high
- tx_oe  out  1  output enable for tx pin
- sum_q  out  8  latched sum[7:0] of current/last frame
- carry_q  out  1  latched carry of current/last frame

Behaviour:
- Single clock domain. Reset is synchronous, active-low: clock port clk, reset port rst_n; rst_n sampled only on rising clk.
- Reset values: tx=1, tx_oe=0, busy=0, done=0, sum_q=0, carry_q=0, state=IDLE, counters=0.
- tx_oe goes to 1 on the first rising edge with rst_n=1 and stays 1 until the next reset.
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, each held CLKS_PER_BIT cycles; order sum[0]..sum[7], then carry.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Accept: at an edge where state=IDLE, ena=1 and start=1:
  - {carry_q,sum_q} <= a_in + b_in, as a 9-bit zero-extended add.
  - state <= START.
- Timing, with accept at edge k:
  - tx=0 and busy=1 from cycle k+1.
  - Frame length is (2+DATA_BITS)*CLKS_PER_BIT = 11*CLKS_PER_BIT cycles.
  - The final STOP cycle is cycle k+11*CLKS_PER_BIT.
  - The next edge returns to IDLE with done=1 and busy=0 for that one cycle.
- done is a registered pulse lasting exactly one cycle. A start seen in the done cycle is accepted (back-to-back frames, no idle gap beyond the stop bit).
- start while busy is ignored. It is not queued, and sum_q/carry_q do not change.
- ena=0 freezes state, bit counter, baud counter and all outputs; no accept occurs. ena=1 resumes exactly where it stopped, so the frame is stretched.
- Inputs a_in/b_in are sampled only at accept; later changes do not affect the frame in flight.
- Reset mid-frame: the next edge with rst_n=0 forces all reset values. The partial frame is abandoned, and tx returns high immediately after that edge.
- Counters:
  - baud counter: 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
  - bit index: 0..DATA_BITS-1, valid in DATA only.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package sum_serial_tx_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - localparams FRAME_BITS=11, IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- Sub-module sum_serial_tx_baud: baud counter with enable (ena) and restart inputs; outputs bit_tick, asserted on the last cycle of each bit period.
- The FSM and shift register stay in the top block.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with start=1 → tx=1, tx_oe=0, busy=0, done=0, sum_q=0x00, carry_q=0. Release → tx_oe=1 after the first edge.
- CLKS_PER_BIT=4, a=0x25, b=0x13, start one cycle:
  - sum_q=0x38, carry_q=0.
  - tx sequence per 4-cycle bit: 0,0,0,0,1,1,1,0,0,0,1.
  - busy high exactly 44 cycles; done pulses at cycle 45.
- a=0xFF, b=0x02 → sum_q=0x01, carry_q=1; data bits 1,0,0,0,0,0,0,0, then carry bit 1.
- start pulsed at cycles 5 and 20 of an active frame with new operands → no change to tx waveform or sum_q; one done only.
- ena low for 7 cycles mid-DATA → tx holds its value; the frame completes 7 cycles later than nominal with an identical bit sequence.
- start held high continuously → consecutive frames; second START begins the cycle after done; rst_n=0 during second frame's DATA → tx=1, busy=0 after that edge; no done.

Source files
------------

// File: rtl/sum_serial_tx_pkg.sv
// Shared types and constants for the serial sum transmitter.
package sum_serial_tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int   FRAME_BITS  = 11;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic logic [8:0] add9(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/sum_serial_tx_if.sv
// Operand/request and serial-line signals between the operand logic and the transmitter.
interface sum_serial_tx_if;
  logic       ena;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       start;
  logic       busy;
  logic       done;
  logic       tx;
  logic       tx_oe;
  logic [7:0] sum_q;
  logic       carry_q;

  modport master (output ena, a_in, b_in, start,
                  input  busy, done, tx, tx_oe, sum_q, carry_q);
  modport slave  (input  ena, a_in, b_in, start,
                  output busy, done, tx, tx_oe, sum_q, carry_q);
endinterface

// File: rtl/sum_serial_tx_baud.sv
// Bit-period counter; bit_tick marks the last cycle of each serial bit.
module sum_serial_tx_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic restart,
  input  logic run,
  output logic bit_tick
);

  logic [7:0] cnt;

  assign bit_tick = run && (cnt == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (restart)
        cnt <= '0;
      else if (run)
        cnt <= bit_tick ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/sum_serial_tx.sv
// Captures a+b on request and sends the 9-bit sum LSB-first as a start/data/stop frame.
module sum_serial_tx
  import sum_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  sum_serial_tx_if.slave  bus
);

  localparam int IDX_W = $clog2(DATA_BITS);

  state_t                 state;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   frame_data;
  logic                   bit_tick;
  logic                   accept;

  assign accept     = bus.ena && bus.start && (state == IDLE);
  assign frame_data = {bus.carry_q, bus.sum_q};

  sum_serial_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (bus.ena),
    .restart  (accept),
    .run      (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_idx     <= '0;
      bus.tx      <= IDLE_LEVEL;
      bus.tx_oe   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.sum_q   <= '0;
      bus.carry_q <= 1'b0;
    end else begin
      bus.tx_oe <= 1'b1;
      if (bus.ena) begin
        bus.done <= 1'b0;
        case (state)
          IDLE: begin
            if (bus.start) begin
              {bus.carry_q, bus.sum_q} <= add9(bus.a_in, bus.b_in);
              state    <= START;
              bus.tx   <= START_LEVEL;
              bus.busy <= 1'b1;
            end
          end
          START: begin
            if (bit_tick) begin
              state   <= DATA;
              bit_idx <= '0;
              bus.tx  <= frame_data[0];
            end
          end
          DATA: begin
            if (bit_tick) begin
              if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                state   <= STOP;
                bit_idx <= '0;
                bus.tx  <= IDLE_LEVEL;
              end else begin
                bit_idx <= bit_idx + 1'b1;
                bus.tx  <= frame_data[bit_idx + 1'b1];
              end
            end
          end
          STOP: begin
            // done lands in an IDLE cycle, so a start seen here is accepted back-to-back
            if (bit_tick) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.tx   <= IDLE_LEVEL;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sum_serial_tx.sv
// Scoreboard bench: stimulus queues expected frames, a negedge monitor checks each finished frame.
module tb_sum_serial_tx;

  localparam int C   = 4;
  localparam int NBT = 11;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         stretch;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  sum_serial_tx_if bus();

  sum_serial_tx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input int stretch);
    exp_t e;
    e.a = a; e.b = b; e.stretch = stretch;
    exp_q.push_back(e);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic samp [0:1023];
  int   nsamp = 0;
  int   raw   = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic ena_at_edge = 1'b0;

  always @(posedge clk) ena_at_edge <= bus.ena;

  always @(negedge clk) begin
    exp_t        e;
    logic [8:0]  s;
    logic        eb;
    int          errs;
    if (rst_n === 1'b1) begin
      if (bus.busy && !prev_busy) begin
        nsamp = 0;
        raw   = 0;
      end
      if (bus.busy) begin
        raw++;
        if (ena_at_edge) begin
          if (nsamp < 1024) samp[nsamp] = bus.tx;
          nsamp++;
        end
      end
      if (prev_done && ena_at_edge) chk("done_one_cycle", 32'(bus.done), 32'd0);
      if (bus.done && ena_at_edge) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          s = 9'(e.a) + 9'(e.b);
          chk("busy_before_done", 32'(prev_busy), 32'd1);
          chk("frame_len", 32'(nsamp), 32'(NBT * C));
          chk("busy_cycles", 32'(raw), 32'(NBT * C + e.stretch));
          chk("sum_q", 32'(bus.sum_q), 32'(s[7:0]));
          chk("carry_q", 32'(bus.carry_q), 32'(s[8]));
          errs = 0;
          if (nsamp == NBT * C) begin
            for (int i = 0; i < NBT; i++) begin
              if (i == 0)            eb = 1'b0;
              else if (i == NBT - 1) eb = 1'b1;
              else                   eb = s[i-1];
              for (int j = 0; j < C; j++)
                if (samp[i*C + j] !== eb) errs++;
            end
          end
          chk("tx_bits", 32'(errs), 32'd0);
        end
      end
      prev_busy = bus.busy;
      prev_done = bus.done;
    end else begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       hold_tx;
    int         herr;
    logic [7:0] ra, rb;

    rst_n     = 1'b0;
    bus.ena   = 1'b1;
    bus.a_in  = 8'h00;
    bus.b_in  = 8'h00;
    bus.start = 1'b1;
    cyc(3);
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_tx_oe", 32'(bus.tx_oe), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum_q), 32'd0);
    chk("rst_carry", 32'(bus.carry_q), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    cyc();
    chk("tx_oe_after_rst", 32'(bus.tx_oe), 32'd1);
    cyc(2);

    send(8'h25, 8'h13, 0);
    wait_done(200);
    cyc(2);

    send(8'hFF, 8'h02, 0);
    wait_done(200);
    cyc(2);

    // Requests during a frame must be ignored.
    send(8'h5A, 8'h33, 0);
    cyc(4);
    bus.a_in = 8'($urandom); bus.b_in = 8'($urandom); bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("sum_hold_5", 32'(bus.sum_q), 32'h8D);
    cyc(14);
    bus.a_in = 8'($urandom); bus.b_in = 8'($urandom); bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("sum_hold_20", 32'(bus.sum_q), 32'h8D);
    wait_done(200);
    cyc(NBT * C + 5);

    // Freeze mid-DATA for 7 cycles.
    send(8'hA6, 8'h71, 7);
    cyc(15);
    hold_tx = bus.tx;
    herr    = 0;
    bus.ena = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (bus.tx !== hold_tx) herr++;
    end
    bus.ena = 1'b1;
    chk("tx_frozen", 32'(herr), 32'd0);
    wait_done(200);
    cyc(2);

    for (int n = 0; n < 6; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(ra, rb, 0);
      wait_done(200);
      cyc(1 + $urandom_range(0, 3));
    end

    // Continuous start: back-to-back frames, then reset during the second.
    ra = 8'($urandom);
    rb = 8'($urandom);
    exp_q.push_back('{a: ra, b: rb, stretch: 0});
    exp_q.push_back('{a: ra, b: rb, stretch: 0});
    bus.a_in  = ra;
    bus.b_in  = rb;
    bus.start = 1'b1;
    cyc();
    wait_done(200);
    cyc();
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_start_bit", 32'(bus.tx), 32'd0);
    cyc(12);
    rst_n     = 1'b0;
    bus.start = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    cyc();
    chk("midrst_tx", 32'(bus.tx), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    cyc(NBT * C + 10);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
